// File: rtl/mul_arbiter_pkg.sv
// Shared types for the two-requester multiplier arbiter:
// FSM state encoding, requester count and grant-id type.
package mul_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    DONE
  } state_t;

  typedef logic [$clog2(NUM_REQ)-1:0] gid_t;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Two-input round-robin picker: on a tie the pointer wins,
// otherwise the single active requester is granted.
module rr_pick
  import mul_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  gid_t               ptr_i,
  output logic               grant_valid_o,
  output gid_t               grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    if (&req_i) grant_id_o = ptr_i;
    else        grant_id_o = gid_t'(req_i[1]);
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one iterative multiplier between two requesters.
// Define MUL_ARBITER_RR_EN for round-robin; default is fixed priority.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic [WIDTH-1:0]   a0_bi,
  input  logic [WIDTH-1:0]   b0_bi,
  input  logic [WIDTH-1:0]   a1_bi,
  input  logic [WIDTH-1:0]   b1_bi,
  output logic               done0_o,
  output logic               done1_o,
  output logic [2*WIDTH-1:0] y_bo,
  output logic               busy_o,
  output logic               mul_start_o,
  output logic [WIDTH-1:0]   mul_a_bo,
  output logic [WIDTH-1:0]   mul_b_bo,
  input  logic               mul_busy_i,
  input  logic [2*WIDTH-1:0] mul_y_bi
);

  state_t             state_q;
  gid_t               gid_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] y_q;
  logic               done0_q, done1_q;
  logic               start_q, busy_q;
  logic               gnt_v;
  gid_t               gnt_id;

`ifdef MUL_ARBITER_RR_EN
  gid_t ptr_q;

  rr_pick u_pick (
    .req_i         ({req1_i, req0_i}),
    .ptr_i         (ptr_q),
    .grant_valid_o (gnt_v),
    .grant_id_o    (gnt_id)
  );
`else
  always_comb begin
    gnt_v  = req0_i | req1_i;
    gnt_id = req0_i ? gid_t'(0) : gid_t'(1);
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUL_ARBITER_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_v) begin
            gid_q   <= gnt_id;
            a_q     <= gnt_id[0] ? a1_bi : a0_bi;
            b_q     <= gnt_id[0] ? b1_bi : b0_bi;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state_q <= GUARD;
        end
        // busy from the multiplier is not yet valid here
        GUARD: state_q <= WAIT;
        WAIT: begin
          if (!mul_busy_i) begin
            y_q     <= mul_y_bi;
            done0_q <= ~gid_q[0];
            done1_q <= gid_q[0];
            state_q <= DONE;
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          busy_q  <= 1'b0;
`ifdef MUL_ARBITER_RR_EN
          ptr_q   <= ~gid_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done0_o     = done0_q;
  assign done1_o     = done1_q;
  assign y_bo        = y_q;
  assign busy_o      = busy_q;
  assign mul_start_o = start_q;
  assign mul_a_bo    = a_q;
  assign mul_b_bo    = b_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural
// multiplier that stays busy for 8 cycles after start.
module tb_mul_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic [7:0]  a0_bi = '0, b0_bi = '0, a1_bi = '0, b1_bi = '0;
  logic        done0_o, done1_o, busy_o, mul_start_o;
  logic [15:0] y_bo;
  logic [7:0]  mul_a_bo, mul_b_bo;
  logic        mul_busy_i;
  logic [15:0] mul_y_bi;
  logic [3:0]  mcnt;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk_i = ~clk_i;

  mul_arbiter #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0_i      (req0_i),
    .req1_i      (req1_i),
    .a0_bi       (a0_bi),
    .b0_bi       (b0_bi),
    .a1_bi       (a1_bi),
    .b1_bi       (b1_bi),
    .done0_o     (done0_o),
    .done1_o     (done1_o),
    .y_bo        (y_bo),
    .busy_o      (busy_o),
    .mul_start_o (mul_start_o),
    .mul_a_bo    (mul_a_bo),
    .mul_b_bo    (mul_b_bo),
    .mul_busy_i  (mul_busy_i),
    .mul_y_bi    (mul_y_bi)
  );

  // Multiplier model: busy rises the cycle after start, lasts 8 cycles
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcnt     <= '0;
      mul_y_bi <= '0;
    end else if (mul_start_o) begin
      mcnt     <= 4'd8;
      mul_y_bi <= {8'd0, mul_a_bo} * {8'd0, mul_b_bo};
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 4'd1;
    end
  end
  assign mul_busy_i = (mcnt != 0);

  task automatic step_until_done(input int lim, output int cyc,
                                 output int id, output int st,
                                 output logic [7:0] sa,
                                 output logic [7:0] sb);
    cyc = 0; id = -1; st = -1; sa = '0; sb = '0;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk_i); #1;
      if (mul_start_o && st < 0) begin
        st = k; sa = mul_a_bo; sb = mul_b_bo;
      end
      if (done0_o || done1_o) begin
        cyc = k;
        id  = (done0_o && done1_o) ? 2 : (done1_o ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #1;
    total++;
    if ({done0_o, done1_o, busy_o, mul_start_o} !== 4'b0)
      $display("FAIL reset_ctl got %b want 0000",
               {done0_o, done1_o, busy_o, mul_start_o});
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd0) $display("FAIL reset_y got %0d want 0", y_bo);
    else pass_cnt++;
    total++;
    if ({mul_a_bo, mul_b_bo} !== 16'd0)
      $display("FAIL reset_ops got %h want 0000", {mul_a_bo, mul_b_bo});
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single();
    int cyc, id, st;
    logic [7:0] sa, sb;
    a0_bi = 8'd12; b0_bi = 8'd13; req0_i = 1'b1;
    step_until_done(40, cyc, id, st, sa, sb);
    req0_i = 1'b0;
    total++;
    if (st !== 1) $display("FAIL single_start got %0d want 1", st);
    else pass_cnt++;
    total++;
    if ({sa, sb} !== {8'd12, 8'd13})
      $display("FAIL single_ops got %0d,%0d want 12,13", sa, sb);
    else pass_cnt++;
    total++;
    if (cyc !== 11) $display("FAIL single_lat got %0d want 11", cyc);
    else pass_cnt++;
    total++;
    if (id !== 0) $display("FAIL single_id got %0d want 0", id);
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd156) $display("FAIL single_y got %0d want 156", y_bo);
    else pass_cnt++;
    idle(1);
    total++;
    if ({done0_o, busy_o} !== 2'b00)
      $display("FAIL single_end got %b want 00", {done0_o, busy_o});
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int cyc, id, st;
    logic [7:0] sa, sb;
    do_reset();
    a0_bi = 8'd255; b0_bi = 8'd255; a1_bi = 8'd3; b1_bi = 8'd7;
    req0_i = 1'b1; req1_i = 1'b1;
    step_until_done(40, cyc, id, st, sa, sb);
    req0_i = 1'b0;
    total++;
    if (id !== 0 || cyc !== 11)
      $display("FAIL simul_first got id%0d@%0d want id0@11", id, cyc);
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd65025) $display("FAIL simul_y0 got %0d want 65025", y_bo);
    else pass_cnt++;
    step_until_done(40, cyc, id, st, sa, sb);
    req1_i = 1'b0;
    total++;
    if (st !== 2) $display("FAIL simul_start1 got %0d want 2", st);
    else pass_cnt++;
    total++;
    if (id !== 1 || cyc !== 12)
      $display("FAIL simul_second got id%0d@%0d want id1@12", id, cyc);
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd21) $display("FAIL simul_y1 got %0d want 21", y_bo);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_fairness();
    int cyc, id, st, exp_id;
    logic [7:0] sa, sb;
    logic [15:0] exp_y;
    do_reset();
    a0_bi = 8'd2; b0_bi = 8'd3; a1_bi = 8'd5; b1_bi = 8'd7;
    req0_i = 1'b1; req1_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step_until_done(40, cyc, id, st, sa, sb);
`ifdef MUL_ARBITER_RR_EN
      exp_id = t % 2;
`else
      exp_id = 0;
`endif
      exp_y = (exp_id == 1) ? 16'd35 : 16'd6;
      total++;
      if (id !== exp_id || cyc !== ((t == 0) ? 11 : 12))
        $display("FAIL fair_grant%0d got id%0d@%0d want id%0d@%0d",
                 t, id, cyc, exp_id, (t == 0) ? 11 : 12);
      else pass_cnt++;
      total++;
      if (y_bo !== exp_y)
        $display("FAIL fair_y%0d got %0d want %0d", t, y_bo, exp_y);
      else pass_cnt++;
    end
    req0_i = 1'b0; req1_i = 1'b0;
    idle(2);
  endtask

  task automatic test_late_arrival();
    int cyc, id, st;
    logic [7:0] sa, sb;
    do_reset();
    a0_bi = 8'd9; b0_bi = 8'd10; req0_i = 1'b1;
    idle(4);
    a1_bi = 8'd11; b1_bi = 8'd12; req1_i = 1'b1;
    step_until_done(40, cyc, id, st, sa, sb);
    req0_i = 1'b0;
    total++;
    if (st !== -1) $display("FAIL late_nostart got %0d want -1", st);
    else pass_cnt++;
    total++;
    if (id !== 0 || cyc !== 7)
      $display("FAIL late_first got id%0d@%0d want id0@7", id, cyc);
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd90) $display("FAIL late_y0 got %0d want 90", y_bo);
    else pass_cnt++;
    step_until_done(40, cyc, id, st, sa, sb);
    req1_i = 1'b0;
    total++;
    if (st !== 2 || {sa, sb} !== {8'd11, 8'd12})
      $display("FAIL late_issue got %0d:%0d,%0d want 2:11,12", st, sa, sb);
    else pass_cnt++;
    total++;
    if (id !== 1 || cyc !== 12)
      $display("FAIL late_second got id%0d@%0d want id1@12", id, cyc);
    else pass_cnt++;
    total++;
    if ({mul_a_bo, mul_b_bo} !== {8'd11, 8'd12})
      $display("FAIL late_hold got %0d,%0d want 11,12", mul_a_bo, mul_b_bo);
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd132) $display("FAIL late_y1 got %0d want 132", y_bo);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_reset_mid();
    int cyc, id, st;
    logic [7:0] sa, sb;
    logic seen;
    a0_bi = 8'd20; b0_bi = 8'd30; req0_i = 1'b1;
    idle(6);
    rst_i = 1'b0;
    #1;
    total++;
    if ({done0_o, done1_o, busy_o, mul_start_o} !== 4'b0 ||
        {mul_a_bo, mul_b_bo} !== 16'd0)
      $display("FAIL rstmid_ctl got %b/%h want 0000/0000",
               {done0_o, done1_o, busy_o, mul_start_o}, {mul_a_bo, mul_b_bo});
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd0) $display("FAIL rstmid_y got %0d want 0", y_bo);
    else pass_cnt++;
    req0_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) rst_i = 1'b1;
      @(posedge clk_i); #1;
      if (done0_o || done1_o) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rstmid_nodone got 1 want 0");
    else pass_cnt++;
    a0_bi = 8'd4; b0_bi = 8'd5; req0_i = 1'b1;
    step_until_done(40, cyc, id, st, sa, sb);
    req0_i = 1'b0;
    total++;
    if (id !== 0 || cyc !== 11 || y_bo !== 16'd20)
      $display("FAIL rstmid_fresh got id%0d@%0d y%0d want id0@11 y20",
               id, cyc, y_bo);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_zero();
    int cyc, id, st;
    logic [7:0] sa, sb;
    a1_bi = 8'd0; b1_bi = 8'd200; req1_i = 1'b1;
    step_until_done(40, cyc, id, st, sa, sb);
    req1_i = 1'b0;
    total++;
    if (id !== 1 || cyc !== 11)
      $display("FAIL zero_done got id%0d@%0d want id1@11", id, cyc);
    else pass_cnt++;
    total++;
    if (y_bo !== 16'd0) $display("FAIL zero_y got %0d want 0", y_bo);
    else pass_cnt++;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_late_arrival();
    test_reset_mid();
    test_zero();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Sequences and shares one iterative multi-cycle multiplier between two arithmetic requesters, such as the function units that compute cubes and cube roots internally. Each requester presents operands plus a held request. The arbiter grants one requester, issues a single-cycle start to the multiplier, and waits out its busy period. It then returns the product with a one-cycle done pulse to the granted requester only. Placement: between the requesters' multiply ports and the shared multiplier instance.

## Interface
- WIDTH, 8, operand width; product is 2*WIDTH bits
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low (asserted at 0)
- req0_i / req1_i  in  1  multiply request from requester 0 / 1; held high until its done pulse
- a0_bi, b0_bi / a1_bi, b1_bi  in  WIDTH  operands of requester 0 / 1; stable while its request is high
- done0_o / done1_o  out  1  one-cycle pulse: product for requester 0 / 1 valid on y_bo
- y_bo  out  2*WIDTH  last product; holds until the next completion
- busy_o  out  1  high whenever the state is not IDLE
- mul_start_o  out  1  one-cycle start to the multiplier
- mul_a_bo, mul_b_bo  out  WIDTH  operands to the multiplier; registered, held from grant through WAIT
- mul_busy_i  in  1  multiplier busy; rises the cycle after start is sampled
- mul_y_bi  in  2*WIDTH  multiplier result; valid when mul_busy_i falls

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, DONE.
- IDLE
  - No request: stay in IDLE.
  - One or more requests: pick the winner, latch its operands into mul_a_bo/mul_b_bo, record grant_id, go to ISSUE.
- ISSUE: mul_start_o = 1 for this cycle only; go to GUARD.
- GUARD: one cycle in which mul_busy_i is ignored, covering the multiplier's busy-rise latency; go to WAIT.
- WAIT: stay while mul_busy_i = 1. When mul_busy_i = 0, capture mul_y_bi into y_bo and go to DONE.
- DONE: assert done{grant_id}_o for one cycle; update the priority pointer; go to IDLE.
- Requester rule: the requester drops req on the clock edge that ends its done cycle. A req still high in the next IDLE cycle is a new request.
- Arbitration for simultaneous requests: round-robin. The pointer gives priority to the requester not served last. Reset value of the pointer favours requester 0.
- Arithmetic: product is unsigned and full width (2*WIDTH). The arbiter does no truncation or sign handling.
- A request arriving during a transaction waits; it is never dropped. Worst-case wait is one full transaction.
- Reset asserted mid-operation (async):
  - State returns to IDLE at once; pointer is cleared.
  - The in-flight transaction is abandoned, with no done pulse.
  - The multiplier shares this reset and aborts too.

## Timing
- Reset values: done0_o = done1_o = 0, y_bo = 0, busy_o = 0, mul_start_o = 0, mul_a_bo = mul_b_bo = 0, grant_id = 0, pointer = 0.
- Let N be the number of cycles mul_busy_i stays high.
- Latency: request seen in IDLE (cycle 0) → ISSUE (cycle 1) → GUARD (cycle 2) → WAIT for N cycles → DONE at cycle 3+N.
- Back-to-back: the next grant happens in the IDLE cycle at 4+N. Throughput is one product per N+4 cycles.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration
- MUL_ARBITER_RR_EN defined: round-robin arbitration as described above.
- MUL_ARBITER_RR_EN undefined: fixed priority, with requester 0 always winning a tie. The pointer register and rr_pick logic are removed.
- Handshake and timing are identical in both builds.

## Structure
- Package mul_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, GUARD, WAIT, DONE) and its encoding width
  - localparam NUM_REQ = 2
  - the grant-id type
- Sub-module rr_pick: combinational 2-input round-robin picker.
  - Inputs: req[1:0], pointer.
  - Outputs: grant_valid, grant_id.
  - Instantiated only under MUL_ARBITER_RR_EN.

## Test plan
- Bench model for the multiplier: start sampled, busy rises the next cycle, busy stays high for N = 8 cycles.
- Single request: req0 with a = 12, b = 13 → mul_start_o pulses at cycle 1; done0_o at cycle 11 with y_bo = 156; done1_o stays 0.
- Simultaneous requests from reset: req0 (a = 255, b = 255) and req1 (a = 3, b = 7), both held.
  - First, done0_o with y_bo = 65025.
  - Next, done1_o with y_bo = 21, issued at the IDLE cycle right after.
- Fairness (round-robin build): both requests permanently re-asserted for 6 transactions → grants alternate 0,1,0,1,0,1. Without the macro, all six grants go to requester 0.
- Late arrival: req1 rises during requester 0's WAIT → no start until requester 0's done. Requester 1 is served next and its operands are unchanged on mul_a_bo/mul_b_bo.
- Reset mid-WAIT: pull rst_i low at cycle 6 of a transaction → no done pulse; all outputs return to reset values asynchronously; a fresh request after release completes normally.
- Zero operand: req1 with a = 0, b = 200 → done1_o with y_bo = 0 at cycle 11.
